// File: rtl/pcie_subsys_pkg.sv
// Shared AXI constants, burst encoding and FSM state types
// for the XDMA AXI-bypass BRAM slave.
package pcie_subsys_pkg;

   localparam int AXIB_ADDR_W = 32;
   localparam int AXIB_DATA_W = 256;
   localparam int AXIB_ID_W   = 4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Only full-width beats are supported: 2**5 = 32 bytes.
   localparam logic [2:0] AXIB_SIZE = 3'd5;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } axi_burst_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_READ,
      R_DATA
   } rd_state_e;

   function automatic logic burst_legal(
      input logic [2:0] size,
      input logic [1:0] burst
   );
      return (size == AXIB_SIZE) &&
             ((burst == FIXED) || (burst == INCR));
   endfunction

endpackage

// File: rtl/axib_bram_slave_if.sv
// AXI4 slave bus bundle between the XDMA m_axib master
// and the BRAM slave.
interface axib_bram_slave_if
   import pcie_subsys_pkg::*;
#(
   parameter int ADDR_W = AXIB_ADDR_W,
   parameter int DATA_W = AXIB_DATA_W,
   parameter int ID_W   = AXIB_ID_W
);

   logic [ID_W-1:0]     s_axi_awid;
   logic [ADDR_W-1:0]   s_axi_awaddr;
   logic [7:0]          s_axi_awlen;
   logic [2:0]          s_axi_awsize;
   logic [1:0]          s_axi_awburst;
   logic [2:0]          s_axi_awprot;
   logic                s_axi_awlock;
   logic [3:0]          s_axi_awcache;
   logic                s_axi_awvalid;
   logic                s_axi_awready;

   logic [DATA_W-1:0]   s_axi_wdata;
   logic [DATA_W/8-1:0] s_axi_wstrb;
   logic                s_axi_wlast;
   logic                s_axi_wvalid;
   logic                s_axi_wready;

   logic [ID_W-1:0]     s_axi_bid;
   logic [1:0]          s_axi_bresp;
   logic                s_axi_bvalid;
   logic                s_axi_bready;

   logic [ID_W-1:0]     s_axi_arid;
   logic [ADDR_W-1:0]   s_axi_araddr;
   logic [7:0]          s_axi_arlen;
   logic [2:0]          s_axi_arsize;
   logic [1:0]          s_axi_arburst;
   logic [2:0]          s_axi_arprot;
   logic                s_axi_arlock;
   logic [3:0]          s_axi_arcache;
   logic                s_axi_arvalid;
   logic                s_axi_arready;

   logic [ID_W-1:0]     s_axi_rid;
   logic [DATA_W-1:0]   s_axi_rdata;
   logic [1:0]          s_axi_rresp;
   logic                s_axi_rlast;
   logic                s_axi_rvalid;
   logic                s_axi_rready;

   modport master (
      output s_axi_awid, s_axi_awaddr, s_axi_awlen,
      output s_axi_awsize, s_axi_awburst, s_axi_awprot,
      output s_axi_awlock, s_axi_awcache, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      output s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
      output s_axi_bready,
      output s_axi_arid, s_axi_araddr, s_axi_arlen,
      output s_axi_arsize, s_axi_arburst, s_axi_arprot,
      output s_axi_arlock, s_axi_arcache, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rid, s_axi_rdata, s_axi_rresp,
      input  s_axi_rlast, s_axi_rvalid,
      output s_axi_rready
   );

   modport slave (
      input  s_axi_awid, s_axi_awaddr, s_axi_awlen,
      input  s_axi_awsize, s_axi_awburst, s_axi_awprot,
      input  s_axi_awlock, s_axi_awcache, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      input  s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bid, s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready,
      input  s_axi_arid, s_axi_araddr, s_axi_arlen,
      input  s_axi_arsize, s_axi_arburst, s_axi_arprot,
      input  s_axi_arlock, s_axi_arcache, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rid, s_axi_rdata, s_axi_rresp,
      output s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready
   );

endinterface

// File: rtl/axib_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered
// read port, read-first when both ports hit the same word.
module axib_sdp_ram #(
   parameter int DATA_W = 256,
   parameter int DEPTH  = 64
) (
   input  logic                     clk,
   input  logic [DATA_W/8-1:0]      we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);

   localparam int STRB_W = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Non-blocking update of both mem and rdata gives old data
   // to a read that collides with a write.
   always_ff @(posedge clk) begin
      for (int b = 0; b < STRB_W; b++) begin
         if (we[b]) begin
            mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axib_bram_slave.sv
// AXI4 BRAM slave behind the XDMA AXI-bypass master:
// independent write and read FSMs over one SDP RAM.
module axib_bram_slave
   import pcie_subsys_pkg::*;
#(
   parameter int ADDR_W    = AXIB_ADDR_W,
   parameter int DATA_W    = AXIB_DATA_W,
   parameter int ID_W      = AXIB_ID_W,
   parameter int MEM_DEPTH = 64
) (
   input logic              axi_aclk,
   input logic              axi_aresetn,
   axib_bram_slave_if.slave s
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_DEPTH);

   // Holds the address channels closed until the first edge
   // after reset release.
   logic up;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         up <= 1'b0;
      end else begin
         up <= 1'b1;
      end
   end

   wr_state_e         w_state;
   wr_state_e         w_next;
   logic [ID_W-1:0]   w_id;
   logic [IDX_W-1:0]  w_idx;
   logic [7:0]        w_len;
   logic              w_fixed;
   logic              w_ok;
   logic [8:0]        w_cnt;
   logic [1:0]        w_resp;
   logic              aw_hs;
   logic              w_hs;
   logic              b_hs;
   logic              w_keep;
   logic [STRB_W-1:0] ram_we;

   assign aw_hs = s.s_axi_awvalid && s.s_axi_awready;
   assign w_hs  = s.s_axi_wvalid && s.s_axi_wready;
   assign b_hs  = s.s_axi_bvalid && s.s_axi_bready;

   // Beats past len+1 are still accepted, just dropped.
   assign w_keep = w_ok && (w_cnt <= {1'b0, w_len});
   assign ram_we = (w_hs && w_keep) ? s.s_axi_wstrb : '0;

   always_comb begin
      w_next = w_state;
      unique case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && s.s_axi_wlast) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         w_state <= W_IDLE;
         w_id    <= '0;
         w_idx   <= '0;
         w_len   <= '0;
         w_fixed <= 1'b0;
         w_ok    <= 1'b0;
         w_cnt   <= '0;
         w_resp  <= RESP_OKAY;
      end else begin
         w_state <= w_next;
         if (aw_hs) begin
            w_id    <= s.s_axi_awid;
            w_idx   <= s.s_axi_awaddr[OFF_W +: IDX_W];
            w_len   <= s.s_axi_awlen;
            w_fixed <= (s.s_axi_awburst == FIXED);
            w_ok    <= burst_legal(s.s_axi_awsize,
                                   s.s_axi_awburst);
            w_cnt   <= '0;
         end
         if (w_hs) begin
            if (!w_fixed) begin
               w_idx <= w_idx + IDX_W'(1);
            end
            // Saturate so runaway bursts never alias len+1.
            if (w_cnt != 9'h100) begin
               w_cnt <= w_cnt + 9'd1;
            end
            if (s.s_axi_wlast) begin
               w_resp <= (w_ok && (w_cnt == {1'b0, w_len}))
                         ? RESP_OKAY : RESP_SLVERR;
            end
         end
      end
   end

   assign s.s_axi_awready = up && (w_state == W_IDLE);
   assign s.s_axi_wready  = (w_state == W_DATA);
   assign s.s_axi_bvalid  = (w_state == W_RESP);
   assign s.s_axi_bid     = w_id;
   assign s.s_axi_bresp   = w_resp;

   rd_state_e         r_state;
   rd_state_e         r_next;
   logic [ID_W-1:0]   r_id;
   logic [IDX_W-1:0]  r_idx;
   logic [7:0]        r_len;
   logic [7:0]        r_beat;
   logic              r_fixed;
   logic              r_ok;
   logic              ar_hs;
   logic              r_hs;
   logic              r_last;
   logic              ram_re;
   logic [DATA_W-1:0] ram_q;

   assign ar_hs  = s.s_axi_arvalid && s.s_axi_arready;
   assign r_hs   = s.s_axi_rvalid && s.s_axi_rready;
   assign r_last = (r_state == R_DATA) && (r_beat == r_len);
   assign ram_re = (r_state == R_READ);

   always_comb begin
      r_next = r_state;
      unique case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_READ;
         R_READ:  r_next = R_DATA;
         R_DATA:  if (r_hs) r_next = r_last ? R_IDLE : R_READ;
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state <= R_IDLE;
         r_id    <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_fixed <= 1'b0;
         r_ok    <= 1'b0;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            r_id    <= s.s_axi_arid;
            r_idx   <= s.s_axi_araddr[OFF_W +: IDX_W];
            r_len   <= s.s_axi_arlen;
            r_beat  <= '0;
            r_fixed <= (s.s_axi_arburst == FIXED);
            r_ok    <= burst_legal(s.s_axi_arsize,
                                   s.s_axi_arburst);
         end
         if (r_hs) begin
            r_beat <= r_beat + 8'd1;
            if (!r_fixed) begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
      end
   end

   assign s.s_axi_arready = up && (r_state == R_IDLE);
   assign s.s_axi_rvalid  = (r_state == R_DATA);
   assign s.s_axi_rlast   = r_last;
   assign s.s_axi_rid     = r_id;
   assign s.s_axi_rresp   = r_ok ? RESP_OKAY : RESP_SLVERR;
   assign s.s_axi_rdata   = r_ok ? ram_q : '0;

   axib_sdp_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_DEPTH)
   ) u_ram (
      .clk   (axi_aclk),
      .we    (ram_we),
      .waddr (w_idx),
      .wdata (s.s_axi_wdata),
      .re    (ram_re),
      .raddr (r_idx),
      .rdata (ram_q)
   );

   // Address bits outside the word index and the prot/lock/
   // cache attributes do not affect this memory.
   logic unused_ok;
   assign unused_ok = ^{
      s.s_axi_awaddr[ADDR_W-1:OFF_W+IDX_W],
      s.s_axi_awaddr[OFF_W-1:0],
      s.s_axi_araddr[ADDR_W-1:OFF_W+IDX_W],
      s.s_axi_araddr[OFF_W-1:0],
      s.s_axi_awprot, s.s_axi_awlock, s.s_axi_awcache,
      s.s_axi_arprot, s.s_axi_arlock, s.s_axi_arcache
   };

endmodule

// File: tb/tb_axib_bram_slave.sv
// Directed and randomized bench for axib_bram_slave with a
// word-array memory model.
module tb_axib_bram_slave;
   import pcie_subsys_pkg::*;

   localparam int DW = 256;
   localparam int IW = 4;
   localparam int AW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   axib_bram_slave_if #(
      .ADDR_W (AW), .DATA_W (DW), .ID_W (IW)
   ) bus ();

   axib_bram_slave #(
      .ADDR_W (AW), .DATA_W (DW), .ID_W (IW), .MEM_DEPTH (64)
   ) dut (
      .axi_aclk    (clk),
      .axi_aresetn (rst_n),
      .s           (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] mem [64];
   logic [DW-1:0] bdata [$];
   logic [SW-1:0] bstrb [$];

   task automatic chk(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic push(input logic [DW-1:0] d,
                       input logic [SW-1:0] st);
      bdata.push_back(d);
      bstrb.push_back(st);
   endtask

   task automatic aw_send(input logic [IW-1:0] id,
                          input logic [AW-1:0] addr,
                          input logic [7:0] len,
                          input logic [2:0] size,
                          input logic [1:0] burst);
      int n = 0;
      bus.s_axi_awid    = id;
      bus.s_axi_awaddr  = addr;
      bus.s_axi_awlen   = len;
      bus.s_axi_awsize  = size;
      bus.s_axi_awburst = burst;
      bus.s_axi_awprot  = 3'($urandom);
      bus.s_axi_awlock  = 1'($urandom);
      bus.s_axi_awcache = 4'($urandom);
      bus.s_axi_awvalid = 1'b1;
      while (!bus.s_axi_awready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("awready", DW'(bus.s_axi_awready), DW'(1));
      @(posedge clk);
      @(negedge clk);
      bus.s_axi_awvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [IW-1:0] id,
                          input logic [AW-1:0] addr,
                          input logic [7:0] len,
                          input logic [2:0] size,
                          input logic [1:0] burst);
      int n = 0;
      bus.s_axi_arid    = id;
      bus.s_axi_araddr  = addr;
      bus.s_axi_arlen   = len;
      bus.s_axi_arsize  = size;
      bus.s_axi_arburst = burst;
      bus.s_axi_arprot  = 3'($urandom);
      bus.s_axi_arlock  = 1'($urandom);
      bus.s_axi_arcache = 4'($urandom);
      bus.s_axi_arvalid = 1'b1;
      while (!bus.s_axi_arready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("arready", DW'(bus.s_axi_arready), DW'(1));
      @(posedge clk);
      @(negedge clk);
      bus.s_axi_arvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [DW-1:0] d,
                         input logic [SW-1:0] st,
                         input logic last);
      int n = 0;
      bus.s_axi_wdata  = d;
      bus.s_axi_wstrb  = st;
      bus.s_axi_wlast  = last;
      bus.s_axi_wvalid = 1'b1;
      while (!bus.s_axi_wready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("wready", DW'(bus.s_axi_wready), DW'(1));
      @(posedge clk);
      @(negedge clk);
      bus.s_axi_wvalid = 1'b0;
      bus.s_axi_wlast  = 1'b0;
   endtask

   task automatic b_recv(input logic [IW-1:0] eid,
                         input logic [1:0] er,
                         input int hold,
                         input string tag);
      int n = 0;
      while (!bus.s_axi_bvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_bvalid"}, DW'(bus.s_axi_bvalid), DW'(1));
      repeat (hold) begin
         @(negedge clk);
         chk({tag, "_bhold"}, DW'(bus.s_axi_bvalid), DW'(1));
         chk({tag, "_aw_blk"}, DW'(bus.s_axi_awready), DW'(0));
      end
      chk({tag, "_bid"}, DW'(bus.s_axi_bid), DW'(eid));
      chk({tag, "_bresp"}, DW'(bus.s_axi_bresp), DW'(er));
      bus.s_axi_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_axi_bready = 1'b0;
      chk({tag, "_bdrop"}, DW'(bus.s_axi_bvalid), DW'(0));
   endtask

   task automatic r_beat(input logic [DW-1:0] ed,
                         input logic [1:0] er,
                         input logic el,
                         input logic [IW-1:0] eid,
                         input int stall,
                         input string tag,
                         output int waited);
      int n = 0;
      while (!bus.s_axi_rvalid && n < 50) begin
         @(negedge clk);
         n++;
      end
      waited = n;
      chk({tag, "_rvalid"}, DW'(bus.s_axi_rvalid), DW'(1));
      repeat (stall) begin
         @(negedge clk);
         chk({tag, "_hold_v"}, DW'(bus.s_axi_rvalid), DW'(1));
         chk({tag, "_hold_d"}, bus.s_axi_rdata, ed);
         chk({tag, "_hold_id"}, DW'(bus.s_axi_rid), DW'(eid));
      end
      chk({tag, "_rdata"}, bus.s_axi_rdata, ed);
      chk({tag, "_rresp"}, DW'(bus.s_axi_rresp), DW'(er));
      chk({tag, "_rlast"}, DW'(bus.s_axi_rlast), DW'(el));
      chk({tag, "_rid"}, DW'(bus.s_axi_rid), DW'(eid));
      bus.s_axi_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.s_axi_rready = 1'b0;
      chk({tag, "_rdrop"}, DW'(bus.s_axi_rvalid), DW'(0));
   endtask

   task automatic wr_burst(input logic [IW-1:0] id,
                           input logic [AW-1:0] addr,
                           input logic [7:0] len,
                           input logic [2:0] size,
                           input logic [1:0] burst,
                           input int hold,
                           input string tag);
      logic legal;
      logic [5:0] idx;
      int nb;
      nb = bdata.size();
      legal = (size == 3'd5) && (burst == 2'b00 || burst == 2'b01);
      idx = addr[10:5];
      aw_send(id, addr, len, size, burst);
      for (int i = 0; i < nb; i++) begin
         w_beat(bdata[i], bstrb[i], i == nb - 1);
         if (legal && i <= int'(len)) begin
            for (int b = 0; b < SW; b++) begin
               if (bstrb[i][b]) mem[idx][b*8 +: 8] = bdata[i][b*8 +: 8];
            end
         end
         if (burst == 2'b01) idx = idx + 6'd1;
      end
      b_recv(id, (legal && nb == int'(len) + 1) ?
             RESP_OKAY : RESP_SLVERR, hold, tag);
      bdata.delete();
      bstrb.delete();
   endtask

   task automatic rd_burst(input logic [IW-1:0] id,
                           input logic [AW-1:0] addr,
                           input logic [7:0] len,
                           input logic [2:0] size,
                           input logic [1:0] burst,
                           input int sb,
                           input int sc,
                           input string tag);
      logic legal;
      logic [5:0] idx;
      logic [DW-1:0] ed;
      int w;
      legal = (size == 3'd5) && (burst == 2'b00 || burst == 2'b01);
      idx = addr[10:5];
      ar_send(id, addr, len, size, burst);
      for (int i = 0; i <= int'(len); i++) begin
         ed = legal ? mem[idx] : '0;
         r_beat(ed, legal ? RESP_OKAY : RESP_SLVERR,
                i == int'(len), id, (i == sb) ? sc : 0, tag, w);
         chk({tag, "_lat"}, DW'(w + 1), DW'(2));
         if (burst == 2'b01) idx = idx + 6'd1;
      end
   endtask

   initial begin
      logic [DW-1:0] old;
      logic [DW-1:0] nw;
      logic [IW-1:0] rid;
      logic [AW-1:0] ra;
      logic [7:0] rl;
      logic [2:0] rs;
      logic [1:0] rb;
      int k;
      int nb;
      int dummy;

      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
      bus.s_axi_wlast   = 1'b0;
      bus.s_axi_wdata   = '0;
      bus.s_axi_wstrb   = '0;
      bus.s_axi_bready  = 1'b0;
      bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready  = 1'b0;
      bus.s_axi_awid = '0; bus.s_axi_awaddr = '0;
      bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
      bus.s_axi_awburst = '0; bus.s_axi_awprot = '0;
      bus.s_axi_awlock = '0; bus.s_axi_awcache = '0;
      bus.s_axi_arid = '0; bus.s_axi_araddr = '0;
      bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
      bus.s_axi_arburst = '0; bus.s_axi_arprot = '0;
      bus.s_axi_arlock = '0; bus.s_axi_arcache = '0;

      repeat (3) @(negedge clk);
      chk("rst_awready", DW'(bus.s_axi_awready), DW'(0));
      chk("rst_wready", DW'(bus.s_axi_wready), DW'(0));
      chk("rst_bvalid", DW'(bus.s_axi_bvalid), DW'(0));
      chk("rst_arready", DW'(bus.s_axi_arready), DW'(0));
      chk("rst_rvalid", DW'(bus.s_axi_rvalid), DW'(0));
      chk("rst_rlast", DW'(bus.s_axi_rlast), DW'(0));
      rst_n = 1'b1;
      #1;
      chk("rel_awready_pre", DW'(bus.s_axi_awready), DW'(0));
      @(posedge clk);
      #1;
      chk("rel_awready", DW'(bus.s_axi_awready), DW'(1));
      chk("rel_arready", DW'(bus.s_axi_arready), DW'(1));
      @(negedge clk);

      // Fill every word, then read back via the 2 KiB alias.
      for (int i = 0; i < 64; i++) push(rnd_word(), '1);
      wr_burst(4'h0, 32'h0, 8'd63, 3'd5, 2'b01, 0, "preload");
      rd_burst(4'h1, 32'h800, 8'd63, 3'd5, 2'b01, 10, 2, "pre_rd");

      push({32{8'hA5}}, '1);
      wr_burst(4'h1, 32'h40, 8'd0, 3'd5, 2'b01, 0, "single");
      rd_burst(4'h2, 32'h40, 8'd0, 3'd5, 2'b01, -1, 0, "single_rd");

      for (int i = 0; i < 4; i++) push(rnd_word(), '1);
      wr_burst(4'h4, 32'h7E0, 8'd3, 3'd5, 2'b01, 0, "wrap");
      rd_burst(4'h5, 32'h7E0, 8'd3, 3'd5, 2'b01, -1, 0, "wrap_rd");
      rd_burst(4'h6, 32'h0, 8'd1, 3'd5, 2'b01, -1, 0, "wrap_rd0");

      push('1, '1);
      wr_burst(4'h7, 32'h300, 8'd0, 3'd5, 2'b01, 0, "ones");
      push('0, 32'h0000_000F);
      wr_burst(4'h7, 32'h300, 8'd0, 3'd5, 2'b01, 0, "strb");
      rd_burst(4'h8, 32'h300, 8'd0, 3'd5, 2'b01, -1, 0, "strb_rd");
      push({32{8'h55}}, '1);
      wr_burst(4'h9, 32'h300, 8'd0, 3'd4, 2'b01, 0, "size4");
      rd_burst(4'h8, 32'h300, 8'd0, 3'd5, 2'b01, -1, 0, "size4_rd");

      for (int i = 0; i < 3; i++) push(rnd_word(), '1);
      wr_burst(4'hA, 32'h500, 8'd2, 3'd5, 2'b01, 3, "bp_w");
      rd_burst(4'hB, 32'h500, 8'd2, 3'd5, 2'b01, 1, 5, "bp_r");

      for (int i = 0; i < 2; i++) push(rnd_word(), '1);
      wr_burst(4'hC, 32'h600, 8'd3, 3'd5, 2'b01, 0, "early");
      rd_burst(4'hC, 32'h600, 8'd3, 3'd5, 2'b01, -1, 0, "early_rd");

      for (int i = 0; i < 4; i++) push(rnd_word(), '1);
      wr_burst(4'hD, 32'h700, 8'd1, 3'd5, 2'b01, 0, "extra");
      rd_burst(4'hD, 32'h700, 8'd3, 3'd5, 2'b01, -1, 0, "extra_rd");

      for (int i = 0; i < 3; i++) push(rnd_word(), 32'($urandom));
      wr_burst(4'hE, 32'h1A0, 8'd2, 3'd5, 2'b00, 0, "fixed");
      rd_burst(4'hE, 32'h1A0, 8'd2, 3'd5, 2'b00, -1, 0, "fixed_rd");

      for (int i = 0; i < 2; i++) push(rnd_word(), '1);
      wr_burst(4'hF, 32'h1C0, 8'd1, 3'd5, 2'b10, 0, "wrapb");
      rd_burst(4'hF, 32'h1C0, 8'd1, 3'd5, 2'b10, -1, 0, "wrapb_rd");
      rd_burst(4'h3, 32'h1C0, 8'd1, 3'd5, 2'b01, -1, 0, "wrapb_chk");

      // Write beat lands on the same edge as the RAM read.
      old = mem[10];
      nw = rnd_word();
      aw_send(4'h3, 32'h140, 8'd0, 3'd5, 2'b01);
      ar_send(4'h5, 32'h140, 8'd0, 3'd5, 2'b01);
      w_beat(nw, '1, 1'b1);
      r_beat(old, RESP_OKAY, 1'b1, 4'h5, 0, "coll", dummy);
      mem[10] = nw;
      b_recv(4'h3, RESP_OKAY, 0, "coll_b");
      rd_burst(4'h6, 32'h140, 8'd0, 3'd5, 2'b01, -1, 0, "coll_new");

      ar_send(4'h9, 32'h40, 8'd0, 3'd5, 2'b01);
      @(negedge clk);
      chk("mid_rvalid_pre", DW'(bus.s_axi_rvalid), DW'(1));
      chk("mid_rlast_pre", DW'(bus.s_axi_rlast), DW'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rvalid", DW'(bus.s_axi_rvalid), DW'(0));
      chk("mid_rlast", DW'(bus.s_axi_rlast), DW'(0));
      chk("mid_arready", DW'(bus.s_axi_arready), DW'(0));
      chk("mid_awready", DW'(bus.s_axi_awready), DW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rel_arready", DW'(bus.s_axi_arready), DW'(1));
      chk("mid_rel_awready", DW'(bus.s_axi_awready), DW'(1));
      @(negedge clk);
      rd_burst(4'h2, 32'h40, 8'd0, 3'd5, 2'b01, -1, 0, "post_rst");

      for (int it = 0; it < 25; it++) begin
         rid = 4'($urandom);
         ra = $urandom;
         rl = 8'($urandom_range(0, 5));
         k = int'($urandom_range(0, 9));
         rb = (k < 4) ? 2'b01 : (k < 7) ? 2'b00 :
              (k < 8) ? 2'b10 : 2'b11;
         rs = ($urandom_range(0, 5) == 0) ?
              3'($urandom_range(0, 4)) : 3'd5;
         nb = ($urandom_range(0, 4) == 0) ?
              int'($urandom_range(1, int'(rl) + 3)) : int'(rl) + 1;
         for (int i = 0; i < nb; i++) begin
            push(rnd_word(), ($urandom_range(0, 2) == 0) ?
                 '1 : 32'($urandom));
         end
         wr_burst(rid, ra, rl, rs, rb,
                  int'($urandom_range(0, 2)), "rnd_w");
         rd_burst(~rid, ra, rl, rs, rb,
                  int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 3)), "rnd_r");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
